// File: rtl/ex_stage.sv
// Execute stage: ALU, overflow/zero/branch resolution and the EX/MEM pipeline register,
// plus a sticky flag and saturating counter for illegal ALU control codes.
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             branch_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             branch_taken,
  output logic [WIDTH-1:0] store_data_out,
  output logic [4:0]       rd_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] res_c;
  logic [WIDTH:0]   slt_diff;
  logic             ovf_c;
  logic             legal_c;
  logic             zero_c;
  logic             taken_c;
  logic             rw_c;
  logic             mr_c;
  logic             mw_c;
  logic             load;
  logic             count_en;

  always_comb begin
    res_c    = '0;
    ovf_c    = 1'b0;
    legal_c  = 1'b1;
    // one extra bit keeps slt correct when a-b overflows WIDTH bits
    slt_diff = {op_a[WIDTH-1], op_a} - {op_b[WIDTH-1], op_b};
    case (alu_ctrl)
      ALU_AND: res_c = op_a & op_b;
      ALU_OR:  res_c = op_a | op_b;
      ALU_ADD: begin
        res_c = op_a + op_b;
        ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res_c[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_c = op_a - op_b;
        ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res_c[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, slt_diff[WIDTH]};
      default: legal_c = 1'b0;
    endcase
  end

  assign zero_c   = legal_c && (res_c == '0);
  assign taken_c  = branch_in & zero_c;
  assign rw_c     = legal_c & reg_write_in & ~ovf_c;
  assign mr_c     = legal_c & mem_read_in;
  assign mw_c     = legal_c & mem_write_in;
  assign load     = !flush && !stall;
  assign count_en = load && in_valid && !legal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      zero           <= 1'b0;
      overflow       <= 1'b0;
      branch_taken   <= 1'b0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (flush || (load && !in_valid)) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      zero           <= 1'b0;
      overflow       <= 1'b0;
      branch_taken   <= 1'b0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (load) begin
      out_valid      <= 1'b1;
      alu_result     <= res_c;
      zero           <= zero_c;
      overflow       <= ovf_c;
      branch_taken   <= taken_c;
      store_data_out <= store_data_in;
      rd_out         <= rd_in;
      reg_write_out  <= rw_c;
      mem_read_out   <= mr_c;
      mem_write_out  <= mw_c;
    end
  end

  // a clear coinciding with a counted illegal load leaves exactly that one event recorded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_sticky <= 1'b0;
      illegal_count  <= '0;
    end else if (clr_err) begin
      illegal_sticky <= count_en;
      illegal_count  <= count_en ? CNT_ONE : '0;
    end else if (count_en) begin
      illegal_sticky <= 1'b1;
      if (illegal_count != CNT_MAX) illegal_count <= illegal_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table vectors, scoreboard queue of expected EX/MEM contents,
// hand sequences for stall/flush, counter saturation, clear and async reset.
module tb_ex_stage;

  typedef struct {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br;
  } stim_t;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic        z, ovf, bt;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, store_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, branch_in;
  logic        stall, flush, clr_err;
  logic        out_valid;
  logic [31:0] alu_result, store_data_out;
  logic        zero, overflow, branch_taken;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, mem_write_out;
  logic        illegal_sticky;
  logic [7:0]  illegal_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  exp_t zero_exp;
  logic exp_sticky;
  int   exp_count;
  vec_t tbl[14];

  ex_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .branch_in(branch_in),
    .stall(stall), .flush(flush), .clr_err(clr_err),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
    .overflow(overflow), .branch_taken(branch_taken),
    .store_data_out(store_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .illegal_sticky(illegal_sticky),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t st(logic v, logic [3:0] ctrl, logic [31:0] a, logic [31:0] b,
                               logic [31:0] sd, logic [4:0] rd, logic rw, logic mr,
                               logic mw, logic br);
    stim_t s;
    s.v = v; s.ctrl = ctrl; s.a = a; s.b = b; s.sd = sd; s.rd = rd;
    s.rw = rw; s.mr = mr; s.mw = mw; s.br = br;
    return s;
  endfunction

  function automatic exp_t ex(logic v, logic [31:0] res, logic z, logic ovf, logic bt,
                              logic [31:0] sd, logic [4:0] rd, logic rw, logic mr, logic mw);
    exp_t e;
    e.v = v; e.res = res; e.z = z; e.ovf = ovf; e.bt = bt; e.sd = sd; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw;
    return e;
  endfunction

  function automatic logic is_illegal(logic [3:0] c);
    return !(c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111});
  endfunction

  // independent reference using 64-bit signed arithmetic for overflow and slt
  function automatic exp_t model(stim_t s);
    exp_t   e;
    longint sa, sb, r;
    logic   legal;
    sa = longint'($signed(s.a));
    sb = longint'($signed(s.b));
    e = ex(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, s.sd, s.rd, 1'b0, 1'b0, 1'b0);
    legal = !is_illegal(s.ctrl);
    case (s.ctrl)
      4'b0000: e.res = s.a & s.b;
      4'b0001: e.res = s.a | s.b;
      4'b0010: begin r = sa + sb; e.res = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0110: begin r = sa - sb; e.res = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.res = 32'h0;
    endcase
    e.z  = legal && (e.res == 32'h0);
    e.bt = s.br && e.z;
    e.rw = legal && s.rw && !e.ovf;
    e.mr = legal && s.mr;
    e.mw = legal && s.mw;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_err();
    check("illegal_sticky", {31'd0, illegal_sticky}, {31'd0, exp_sticky});
    check("illegal_count", {24'd0, illegal_count}, exp_count);
  endtask

  task automatic compare_out(input exp_t e);
    check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
    check("alu_result", alu_result, e.res);
    check("zero", {31'd0, zero}, {31'd0, e.z});
    check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
    check("store_data_out", store_data_out, e.sd);
    check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
    check("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
    check("mem_read_out", {31'd0, mem_read_out}, {31'd0, e.mr});
    check("mem_write_out", {31'd0, mem_write_out}, {31'd0, e.mw});
  endtask

  // drive one cycle of stimulus, predict EX/MEM and error state, compare after the edge
  task automatic step(input stim_t s, input exp_t e, input logic stl, input logic fl, input logic clr);
    exp_t nxt;
    exp_t got;
    logic cnt_en;
    in_valid = s.v; alu_ctrl = s.ctrl; op_a = s.a; op_b = s.b; store_data_in = s.sd;
    rd_in = s.rd; reg_write_in = s.rw; mem_read_in = s.mr; mem_write_in = s.mw;
    branch_in = s.br; stall = stl; flush = fl; clr_err = clr;
    if (fl)        nxt = zero_exp;
    else if (stl)  nxt = last_exp;
    else if (!s.v) nxt = zero_exp;
    else           nxt = e;
    sb_q.push_back(nxt);
    last_exp = nxt;
    cnt_en = !fl && !stl && s.v && is_illegal(s.ctrl);
    if (clr) begin
      exp_sticky = cnt_en;
      exp_count  = cnt_en ? 1 : 0;
    end else if (cnt_en) begin
      exp_sticky = 1'b1;
      if (exp_count < 255) exp_count++;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      got = sb_q.pop_front();
      compare_out(got);
      check_err();
    end
  endtask

  stim_t s_tmp;

  initial begin
    zero_exp = ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    last_exp = zero_exp;
    exp_sticky = 1'b0;
    exp_count = 0;

    //                v  ctrl     a             b             sd            rd  rw mr mw br
    tbl[0]  = '{st(1, 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h0000AAAA, 5'd1, 1, 0, 0, 0),
                ex(1, 32'h80000000, 0, 1, 0, 32'h0000AAAA, 5'd1, 0, 0, 0)};
    tbl[1]  = '{st(1, 4'b0110, 32'd5, 32'd5, 32'h0, 5'd2, 1, 0, 0, 1),
                ex(1, 32'h0, 1, 0, 1, 32'h0, 5'd2, 1, 0, 0)};
    tbl[2]  = '{st(1, 4'b0110, 32'd5, 32'd4, 32'h0, 5'd2, 1, 0, 0, 1),
                ex(1, 32'h1, 0, 0, 0, 32'h0, 5'd2, 1, 0, 0)};
    tbl[3]  = '{st(1, 4'b0111, 32'h80000000, 32'h00000001, 32'h0, 5'd4, 1, 0, 0, 0),
                ex(1, 32'h1, 0, 0, 0, 32'h0, 5'd4, 1, 0, 0)};
    tbl[4]  = '{st(1, 4'b0111, 32'h00000001, 32'h80000000, 32'h0, 5'd4, 1, 0, 0, 0),
                ex(1, 32'h0, 1, 0, 0, 32'h0, 5'd4, 1, 0, 0)};
    tbl[5]  = '{st(1, 4'b1111, 32'h12345678, 32'h1, 32'h00001234, 5'd3, 1, 1, 1, 1),
                ex(1, 32'h0, 0, 0, 0, 32'h00001234, 5'd3, 0, 0, 0)};
    tbl[6]  = '{st(0, 4'b1111, 32'h1, 32'h1, 32'h00005555, 5'd9, 0, 0, 1, 0),
                ex(0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0, 0, 0)};
    tbl[7]  = '{st(1, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0, 5'd7, 1, 0, 0, 0),
                ex(1, 32'h0000F000, 0, 0, 0, 32'h0, 5'd7, 1, 0, 0)};
    tbl[8]  = '{st(1, 4'b0001, 32'h000000F0, 32'h0000000F, 32'hDEADBEEF, 5'd8, 0, 1, 1, 0),
                ex(1, 32'h000000FF, 0, 0, 0, 32'hDEADBEEF, 5'd8, 0, 1, 1)};
    tbl[9]  = '{st(1, 4'b0110, 32'h80000000, 32'h00000001, 32'h0, 5'd10, 1, 0, 0, 0),
                ex(1, 32'h7FFFFFFF, 0, 1, 0, 32'h0, 5'd10, 0, 0, 0)};
    tbl[10] = '{st(1, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd11, 1, 0, 0, 1),
                ex(1, 32'h0, 1, 0, 1, 32'h0, 5'd11, 1, 0, 0)};
    tbl[11] = '{st(1, 4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h0, 5'd12, 1, 0, 0, 0),
                ex(1, 32'h0, 1, 0, 0, 32'h0, 5'd12, 1, 0, 0)};
    tbl[12] = '{st(1, 4'b0111, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 5'd13, 1, 0, 0, 0),
                ex(1, 32'h1, 0, 0, 0, 32'h0, 5'd13, 1, 0, 0)};
    tbl[13] = '{st(1, 4'b0011, 32'h5, 32'h5, 32'h0, 5'd14, 1, 0, 0, 0),
                ex(1, 32'h0, 0, 0, 0, 32'h0, 5'd14, 0, 0, 0)};

    rst_n = 1'b0;
    in_valid = 0; alu_ctrl = 0; op_a = 0; op_b = 0; store_data_in = 0; rd_in = 0;
    reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; branch_in = 0;
    stall = 0; flush = 0; clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    compare_out(zero_exp);
    check_err();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) step(tbl[i].s, tbl[i].e, 1'b0, 1'b0, 1'b0);

    // hold for three cycles while upstream presents other work, including an illegal code
    step(tbl[7].s, tbl[7].e, 1'b0, 1'b0, 1'b0);
    step(tbl[8].s, tbl[8].e, 1'b1, 1'b0, 1'b0);
    step(tbl[5].s, tbl[5].e, 1'b1, 1'b0, 1'b0);
    step(tbl[0].s, tbl[0].e, 1'b1, 1'b0, 1'b0);
    step(tbl[5].s, tbl[5].e, 1'b1, 1'b1, 1'b0);
    step(tbl[5].s, tbl[5].e, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) step(tbl[5].s, tbl[5].e, 1'b0, 1'b0, 1'b0);
    check("count_saturated", {24'd0, illegal_count}, 32'd255);
    step(tbl[5].s, tbl[5].e, 1'b0, 1'b0, 1'b1);
    check("clr_with_illegal", {24'd0, illegal_count}, 32'd1);
    step(tbl[7].s, tbl[7].e, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      s_tmp.v    = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 6))
        0: s_tmp.ctrl = 4'b0000;
        1: s_tmp.ctrl = 4'b0001;
        2: s_tmp.ctrl = 4'b0010;
        3: s_tmp.ctrl = 4'b0110;
        4: s_tmp.ctrl = 4'b0111;
        5: s_tmp.ctrl = 4'b1111;
        default: s_tmp.ctrl = 4'($urandom_range(8, 14));
      endcase
      s_tmp.a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      s_tmp.b  = ($urandom_range(0, 3) == 0) ? s_tmp.a : $urandom;
      s_tmp.sd = $urandom;
      s_tmp.rd = 5'($urandom_range(0, 31));
      s_tmp.rw = 1'($urandom_range(0, 1));
      s_tmp.mr = 1'($urandom_range(0, 1));
      s_tmp.mw = 1'($urandom_range(0, 1));
      s_tmp.br = 1'($urandom_range(0, 1));
      step(s_tmp, model(s_tmp), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0), 1'b0);
    end

    // asynchronous reset in the middle of a stalled cycle
    step(tbl[8].s, tbl[8].e, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    last_exp = zero_exp;
    exp_sticky = 1'b0;
    exp_count = 0;
    compare_out(zero_exp);
    check_err();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(tbl[12].s, tbl[12].e, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
